// File: rtl/arriskv_pkg.sv
// arriskv_pkg: shared decode types, opcode constants and decoded-instruction bundle
package arriskv_pkg;
  localparam int WD_REGS = 32;
  typedef enum logic [3:0] {R, I, IS, IJ, IL, S, B, U, J} instr_type_t;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef struct packed {
    instr_type_t         typ;
    logic [WD_REGS-1:0]  imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [WD_REGS-1:0]  pc;
    logic                illegal;
  } decoded_instr_t;
endpackage

// File: rtl/instr_decode_stage_skid_buffer.sv
// skid_buffer: two-entry FIFO-ordered skid buffer with registered ready and flush
module skid_buffer #(
  parameter type T = logic
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);
  typedef enum logic [1:0] {EMPTY = 2'b01, ONE = 2'b11, TWO = 2'b10} state_t;
  state_t state_q, state_d;
  T main_q, main_d, skid_q, skid_d;
  logic acc, drn;
  assign o_ready = state_q[0];
  assign o_valid = state_q[1];
  assign o_data  = main_q;
  always_comb begin
    acc     = i_valid & o_ready;
    drn     = o_valid & i_ready;
    main_d  = i_flush ? main_q : (acc & (~o_valid | drn)) ? i_data : (drn & state_q == TWO) ? skid_q : main_q;
    skid_d  = (~i_flush & acc & o_valid & ~drn) ? i_data : skid_q;
    state_d = i_flush          ? EMPTY :
              state_q == EMPTY ? (acc ? ONE : EMPTY) :
              state_q == ONE   ? ((acc & ~drn) ? TWO : (~acc & drn) ? EMPTY : ONE) :
              state_q == TWO   ? (drn ? ONE : TWO) : EMPTY;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: RV32 classify/field-extract decode registered through a skid buffer
module instr_decode_stage
  import arriskv_pkg::*;
#(
  parameter int wd_regs_p  = WD_REGS,
  parameter int wd_instr_p = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [wd_instr_p-1:0] i_instr,
  input  logic [wd_regs_p-1:0] i_pc,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output instr_type_t          o_instr_type,
  output logic [wd_regs_p-1:0] o_immediate,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic [4:0]           o_rd,
  output logic [2:0]           o_funct3,
  output logic [6:0]           o_funct7,
  output logic [wd_regs_p-1:0] o_pc,
  output logic                 o_illegal
);
  decoded_instr_t dec_d, dec_q;
  logic [6:0] opc;
  logic [2:0] f3;
  always_comb begin
    opc            = i_instr[6:0];
    f3             = i_instr[14:12];
    dec_d          = '0;
    dec_d.typ      = opc == OPC_OP_IMM ? ((f3 == 3'b001 || f3 == 3'b101) ? IS : I) :
                     opc == OPC_JALR   ? IJ :
                     opc == OPC_LOAD   ? IL :
                     opc == OPC_STORE  ? S :
                     opc == OPC_BRANCH ? B :
                     (opc == OPC_LUI || opc == OPC_AUIPC) ? U :
                     opc == OPC_JAL    ? J : R;
    dec_d.illegal  = !(opc inside {OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                   OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP});
    dec_d.imm      = dec_d.typ inside {I, IJ, IL} ? WD_REGS'(i_instr[31:20]) :
                     dec_d.typ == IS ? WD_REGS'(i_instr[24:20]) :
                     dec_d.typ == S  ? WD_REGS'({i_instr[31:25], i_instr[11:7]}) :
                     dec_d.typ == B  ? WD_REGS'({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}) :
                     dec_d.typ == U  ? WD_REGS'(i_instr[31:12]) :
                     dec_d.typ == J  ? WD_REGS'({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21]}) : '0;
    dec_d.rd       = i_instr[11:7];
    dec_d.funct3   = f3;
    dec_d.rs1      = i_instr[19:15];
    dec_d.rs2      = i_instr[24:20];
    dec_d.funct7   = i_instr[31:25];
    dec_d.pc       = WD_REGS'(i_pc);
  end
  skid_buffer #(.T(decoded_instr_t)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (dec_d),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (dec_q)
  );
  assign o_instr_type = dec_q.typ;
  assign o_immediate  = wd_regs_p'(dec_q.imm);
  assign o_rs1        = dec_q.rs1;
  assign o_rs2        = dec_q.rs2;
  assign o_rd         = dec_q.rd;
  assign o_funct3     = dec_q.funct3;
  assign o_funct7     = dec_q.funct7;
  assign o_pc         = wd_regs_p'(dec_q.pc);
  assign o_illegal    = dec_q.illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed stimulus checked every cycle against a queue-based decode model
module tb_instr_decode_stage;
  import arriskv_pkg::*;
  logic clk = 0, rst = 1, valid = 0, flush = 0, rdy = 1;
  logic [31:0] instr = '0, pc = '0;
  logic o_ready, o_valid, o_ill;
  instr_type_t o_type;
  logic [31:0] o_imm, o_pc;
  logic [4:0] o_rs1, o_rs2, o_rd;
  logic [2:0] o_f3;
  logic [6:0] o_f7;
  int checks = 0, errors = 0;
  typedef struct {
    instr_type_t typ;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic        ill;
  } exp_t;
  exp_t mq[$];
  logic [31:0] out_log[$];
  instr_decode_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_instr(instr), .i_pc(pc),
    .i_flush(flush), .o_valid(o_valid), .i_ready(rdy), .o_instr_type(o_type), .o_immediate(o_imm),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_f3), .o_funct7(o_f7), .o_pc(o_pc),
    .o_illegal(o_ill)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a);
    exp_t e;
    e.rd = w[11:7]; e.f3 = w[14:12]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f7 = w[31:25];
    e.pc = a; e.ill = 0; e.imm = 0; e.typ = R;
    case (w[6:0])
      7'h13: begin
        e.typ = (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? IS : I;
        e.imm = (e.typ == IS) ? {27'd0, w[24:20]} : {20'd0, w[31:20]};
      end
      7'h67: begin e.typ = IJ; e.imm = {20'd0, w[31:20]}; end
      7'h03: begin e.typ = IL; e.imm = {20'd0, w[31:20]}; end
      7'h23: begin e.typ = S;  e.imm = {20'd0, w[31:25], w[11:7]}; end
      7'h63: begin e.typ = B;  e.imm = {19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
      7'h37, 7'h17: begin e.typ = U; e.imm = {12'd0, w[31:12]}; end
      7'h6f: begin e.typ = J;  e.imm = {12'd0, w[31], w[19:12], w[20], w[30:21]}; end
      7'h33: e.typ = R;
      default: e.ill = 1;
    endcase
    return e;
  endfunction
  task automatic compare_all();
    chk("valid", 32'(o_valid), 32'(mq.size() > 0));
    chk("ready", 32'(o_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      exp_t e;
      e = mq[0];
      chk("type", 32'(o_type), 32'(e.typ));
      chk("imm", o_imm, e.imm);
      chk("rs1", 32'(o_rs1), 32'(e.rs1));
      chk("rs2", 32'(o_rs2), 32'(e.rs2));
      chk("rd", 32'(o_rd), 32'(e.rd));
      chk("funct3", 32'(o_f3), 32'(e.f3));
      chk("funct7", 32'(o_f7), 32'(e.f7));
      chk("pc", o_pc, e.pc);
      chk("illegal", 32'(o_ill), 32'(e.ill));
    end
  endtask
  task automatic tick();
    logic acc, drn;
    acc = valid && mq.size() < 2;
    drn = mq.size() > 0 && rdy;
    if (o_valid && rdy) out_log.push_back(o_pc);
    @(posedge clk);
    if (rst || flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(model(instr, pc));
    end
    #1 compare_all();
  endtask
  task automatic offer(input logic [31:0] w, input logic [31:0] a);
    instr = w; pc = a; valid = 1;
    tick();
    valid = 0;
  endtask
  logic [31:0] sw_tbl [3];
  instr_type_t st_typ [3];
  logic [31:0] st_imm [3];
  logic [31:0] mix [8];
  initial begin
    sw_tbl = '{32'hFE000EE3, 32'h7FDFF0EF, 32'h123452B7};
    st_typ = '{B, J, U};
    st_imm = '{32'h00001FFC, 32'h0007FFFE, 32'h00012345};
    mix = '{32'h00512423, 32'h0040A303, 32'h000280E7, 32'h40725193,
            32'h002081B3, 32'h00000017, 32'h0000007F, 32'hFFF10093};
    rst = 1; tick(); tick(); rst = 0;
    chk("rst_type", 32'(o_type), 32'(R));
    chk("rst_imm", o_imm, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_rd", 32'(o_rd), 32'h0);
    chk("rst_illegal", 32'(o_ill), 32'h0);
    chk("model_pin_j", model(32'h7FDFF0EF, 32'h0).imm, 32'h0007FFFE);
    chk("model_pin_b", model(32'hFE000EE3, 32'h0).imm, 32'h00001FFC);
    rdy = 1;
    offer(32'hFFF10093, 32'h100);
    chk("addi_valid", 32'(o_valid), 32'h1);
    chk("addi_type", 32'(o_type), 32'(I));
    chk("addi_imm", o_imm, 32'h00000FFF);
    chk("addi_rs1", 32'(o_rs1), 32'd2);
    chk("addi_rd", 32'(o_rd), 32'd1);
    tick();
    chk("addi_once", 32'(o_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      instr = sw_tbl[k]; pc = 32'h200 + 32'(4 * k); valid = 1;
      tick();
      chk("stream_type", 32'(o_type), 32'(st_typ[k]));
      chk("stream_imm", o_imm, st_imm[k]);
      chk("stream_ready", 32'(o_ready), 32'h1);
    end
    valid = 0; tick();
    rdy = 0; out_log.delete();
    offer(32'h00512423, 32'h300);
    offer(32'h0040A303, 32'h304);
    chk("bp_ready_low", 32'(o_ready), 32'h0);
    instr = 32'h000280E7; pc = 32'h308; valid = 1;
    tick();
    chk("bp_ready_hold", 32'(o_ready), 32'h0);
    rdy = 1;
    begin
      int n;
      logic took;
      n = 0; took = 0;
      while (!took && n < 10) begin
        took = o_ready;
        tick();
        n++;
      end
      if (!took) chk("bp_accept_timeout", 32'h0, 32'h1);
    end
    valid = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("bp_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      chk("bp_order0", out_log[0], 32'h300);
      chk("bp_order1", out_log[1], 32'h304);
      chk("bp_order2", out_log[2], 32'h308);
    end
    offer(32'h40725193, 32'h400);
    chk("srai_type", 32'(o_type), 32'(IS));
    chk("srai_imm", o_imm, 32'h00000007);
    chk("srai_funct7", 32'(o_f7), 32'h20);
    chk("srai_rd", 32'(o_rd), 32'd3);
    chk("srai_rs1", 32'(o_rs1), 32'd4);
    offer(32'h0000007F, 32'h404);
    chk("ill_type", 32'(o_type), 32'(R));
    chk("ill_imm", o_imm, 32'h0);
    chk("ill_flag", 32'(o_ill), 32'h1);
    tick();
    rdy = 0;
    offer(32'h00512423, 32'h500);
    offer(32'h0040A303, 32'h504);
    instr = 32'h123452B7; pc = 32'h508; valid = 1; flush = 1;
    tick();
    flush = 0; valid = 0;
    chk("flush2_valid", 32'(o_valid), 32'h0);
    chk("flush2_ready", 32'(o_ready), 32'h1);
    rdy = 1; out_log.delete();
    for (int k = 0; k < 3; k++) tick();
    chk("flush2_none", 32'(out_log.size()), 32'd0);
    rdy = 0;
    offer(32'h00512423, 32'h600);
    instr = 32'h123452B7; pc = 32'h604; valid = 1; flush = 1;
    tick();
    flush = 0; valid = 0;
    chk("flush1_valid", 32'(o_valid), 32'h0);
    rdy = 1; tick(); tick();
    rdy = 0;
    offer(32'h00512423, 32'h700);
    offer(32'h0040A303, 32'h704);
    rst = 1; tick(); rst = 0;
    chk("mrst_valid", 32'(o_valid), 32'h0);
    chk("mrst_ready", 32'(o_ready), 32'h1);
    chk("mrst_type", 32'(o_type), 32'(R));
    chk("mrst_pc", o_pc, 32'h0);
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 48; c++) begin
        valid = (c % 4) != 3;
        instr = mix[idx % 8]; pc = 32'h800 + 32'(4 * idx);
        rdy = (c % 5) < 3;
        if (valid && o_ready) idx++;
        tick();
      end
    end
    valid = 0; rdy = 1;
    for (int k = 0; k < 4; k++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
